gpr_operand_sched: RTL

- Sequences the 2-read/1-write warp GPR RAM for the issue stage.
- Accepts one operand-fetch request per instruction (rs1, rs2, optional rs3) and drives the RAM read addresses; rs3 takes a second read cycle.
- Captures the read data into a one-entry output register with valid/ready.
- Forwards writeback traffic to the RAM write port, suppressing writes to r0.

---
 rtl/gpr_operand_sched_pkg.sv | 33 +++
 rtl/gpr_operand_sched_if.sv | 49 ++++
 rtl/gpr_operand_sched_capture.sv | 32 +++
 rtl/gpr_operand_sched.sv | 102 ++++++++++
 4 files changed

// File: rtl/gpr_operand_sched_pkg.sv
// Shared types for the GPR operand scheduler: FSM states, address widths and helper, operand bundle.
// Pure declarations; no latency or flow-control behaviour lives here.
package gpr_operand_sched_pkg;

    localparam int NUM_WARPS = 4;
    localparam int NUM_REGS  = 32;
    localparam int DATAW     = 128;
    localparam int TAGW      = 8;
    localparam int WIDW      = $clog2(NUM_WARPS);
    localparam int REGW      = $clog2(NUM_REGS);
    localparam int ADDRW     = WIDW + REGW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RS3  = 2'd1,
        ST_FULL = 2'd2
    } sched_state_e;

    typedef logic [ADDRW-1:0] gpr_addr_t;
    typedef logic [DATAW-1:0] gpr_data_t;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        gpr_data_t       rs1;
        gpr_data_t       rs2;
        gpr_data_t       rs3;
    } gpr_operands_t;

    function automatic gpr_addr_t gpr_addr(input logic [WIDW-1:0] wid, input logic [REGW-1:0] r);
        return {wid, r};
    endfunction

endpackage

// File: rtl/gpr_operand_sched_if.sv
// Request, operand-output, writeback and GPR RAM port bundle for the operand scheduler.
// slave = scheduler side; master = issue stage / RAM / consumer side.
interface gpr_operand_sched_if;
    import gpr_operand_sched_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WIDW-1:0]   in_wid;
    logic [REGW-1:0]   in_rs1;
    logic [REGW-1:0]   in_rs2;
    logic [REGW-1:0]   in_rs3;
    logic              in_use_rs3;
    logic [TAGW-1:0]   in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [TAGW-1:0]   out_tag;
    gpr_data_t         out_rs1_data;
    gpr_data_t         out_rs2_data;
    gpr_data_t         out_rs3_data;

    logic              wb_valid;
    logic [WIDW-1:0]   wb_wid;
    logic [REGW-1:0]   wb_rd;
    gpr_data_t         wb_data;

    logic              gpr_wren;
    gpr_addr_t         gpr_waddr;
    gpr_data_t         gpr_wdata;
    gpr_addr_t         gpr_raddr1;
    gpr_addr_t         gpr_raddr2;
    gpr_data_t         gpr_rdata1;
    gpr_data_t         gpr_rdata2;

    modport slave (
        input  in_valid, in_wid, in_rs1, in_rs2, in_rs3, in_use_rs3, in_tag,
        input  out_ready, wb_valid, wb_wid, wb_rd, wb_data, gpr_rdata1, gpr_rdata2,
        output in_ready, out_valid, out_tag, out_rs1_data, out_rs2_data, out_rs3_data,
        output gpr_wren, gpr_waddr, gpr_wdata, gpr_raddr1, gpr_raddr2
    );

    modport master (
        output in_valid, in_wid, in_rs1, in_rs2, in_rs3, in_use_rs3, in_tag,
        output out_ready, wb_valid, wb_wid, wb_rd, wb_data, gpr_rdata1, gpr_rdata2,
        input  in_ready, out_valid, out_tag, out_rs1_data, out_rs2_data, out_rs3_data,
        input  gpr_wren, gpr_waddr, gpr_wdata, gpr_raddr1, gpr_raddr2
    );

endinterface

// File: rtl/gpr_operand_sched_capture.sv
// Per-operand capture mux: r0 reads as zero; with GPR_RD_BYPASS_EN a same-cycle write to the read address wins.
// Purely combinational, no flow control.
module gpr_operand_capture
    import gpr_operand_sched_pkg::*;
(
    input  gpr_addr_t rd_addr_i,
    input  gpr_data_t rd_data_i,
    input  logic      wb_wren_i,
    input  gpr_addr_t wb_addr_i,
    input  gpr_data_t wb_data_i,
    output gpr_data_t cap_data_o
);

    always_comb begin
        cap_data_o = rd_data_i;
`ifdef GPR_RD_BYPASS_EN
        if (wb_wren_i && (wb_addr_i == rd_addr_i)) begin
            cap_data_o = wb_data_i;
        end
`endif
        // Zero-forcing is applied last so it overrides any bypassed value.
        if (rd_addr_i[REGW-1:0] == '0) begin
            cap_data_o = '0;
        end
    end

`ifndef GPR_RD_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wb_wren_i, wb_addr_i, wb_data_i, rd_addr_i[ADDRW-1:REGW]};
`endif

endmodule

// File: rtl/gpr_operand_sched.sv
// Sequences 2R/1W GPR RAM reads into a one-entry operand register; latency 1 (2 with rs3), optional GPR_RD_BYPASS_EN.
// in_ready drops while the rs3 read is pending or the output is held; writeback is never stalled.
module gpr_operand_sched
    import gpr_operand_sched_pkg::*;
(
    input  logic clk,
    input  logic reset,
    gpr_operand_sched_if.slave bus
);

    sched_state_e    state_q, state_d;
    gpr_operands_t   ops_q;
    logic [WIDW-1:0] wid_q;
    logic [REGW-1:0] rs3_q;
    logic            accept;
    gpr_data_t       cap1, cap2, cap3;

    assign bus.gpr_wren  = bus.wb_valid && (bus.wb_rd != '0);
    assign bus.gpr_waddr = gpr_addr(bus.wb_wid, bus.wb_rd);
    assign bus.gpr_wdata = bus.wb_data;

    always_comb begin
        bus.gpr_raddr1 = gpr_addr(bus.in_wid, bus.in_rs1);
        bus.gpr_raddr2 = gpr_addr(bus.in_wid, bus.in_rs2);
        if (state_q == ST_RS3) begin
            bus.gpr_raddr1 = gpr_addr(wid_q, rs3_q);
            bus.gpr_raddr2 = gpr_addr(wid_q, rs3_q);
        end
    end

    gpr_operand_capture u_cap_rs1 (
        .rd_addr_i (bus.gpr_raddr1), .rd_data_i (bus.gpr_rdata1),
        .wb_wren_i (bus.gpr_wren),   .wb_addr_i (bus.gpr_waddr),
        .wb_data_i (bus.wb_data),    .cap_data_o(cap1)
    );

    gpr_operand_capture u_cap_rs2 (
        .rd_addr_i (bus.gpr_raddr2), .rd_data_i (bus.gpr_rdata2),
        .wb_wren_i (bus.gpr_wren),   .wb_addr_i (bus.gpr_waddr),
        .wb_data_i (bus.wb_data),    .cap_data_o(cap2)
    );

    // rs3 shares read port 1 during the RS3 cycle.
    gpr_operand_capture u_cap_rs3 (
        .rd_addr_i (bus.gpr_raddr1), .rd_data_i (bus.gpr_rdata1),
        .wb_wren_i (bus.gpr_wren),   .wb_addr_i (bus.gpr_waddr),
        .wb_data_i (bus.wb_data),    .cap_data_o(cap3)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = bus.in_use_rs3 ? ST_RS3 : ST_FULL;
            ST_RS3:  state_d = ST_FULL;
            ST_FULL: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) state_d = bus.in_use_rs3 ? ST_RS3 : ST_FULL;
                    else              state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_FULL) && bus.out_ready);
        bus.out_valid = (state_q == ST_FULL);
    end

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ops_q <= '0;
            wid_q <= '0;
            rs3_q <= '0;
        end else if (accept) begin
            ops_q.tag <= bus.in_tag;
            ops_q.rs1 <= cap1;
            ops_q.rs2 <= cap2;
            if (!bus.in_use_rs3) ops_q.rs3 <= '0;
            wid_q <= bus.in_wid;
            rs3_q <= bus.in_rs3;
        end else if (state_q == ST_RS3) begin
            ops_q.rs3 <= cap3;
        end
    end

    assign bus.out_tag      = ops_q.tag;
    assign bus.out_rs1_data = ops_q.rs1;
    assign bus.out_rs2_data = ops_q.rs2;
    assign bus.out_rs3_data = ops_q.rs3;

endmodule
